sift_orient_hist: RTL and testbench
===================================

Name: sift_orient_hist

Overview:
- Downstream consumer of the CORDIC magnitude/angle stage in the SIFT keypoint-orientation path.
- Per-pixel gradient magnitude and angle from that stage feed a 36-bin orientation histogram, accumulated over a fixed window of WIN_SIZE samples.
- After the window is complete, the block scans the bins and reports the dominant orientation bin and its peak value.
- Then it clears and accepts the next window.

Parameters:
- WIN_SIZE, 256: valid samples per window (16x16 patch); range 2..65535.
- MAG_W, 16: magnitude input width (matches CORDIC ox).
- ANG_W, 16: angle input width (matches CORDIC oz).
- ACC_W, 24: bin accumulator width; must be >= MAG_W.

Ports:
- iclk, input, 1: clock.
- ireset, input, 1: synchronous, active-high reset.
- ivalid, input, 1: sample valid.
- imag, input, MAG_W: gradient magnitude, unsigned.
- iangle, input, ANG_W: angle, unsigned; 0..2^ANG_W-1 maps to [0,360).
- oready, output, 1: block accepts samples.
- ovalid, output, 1: one-cycle result strobe.
- odir, output, 6: dominant bin index, 0..35 (10 degrees per bin).
- opeak, output, ACC_W: value of the dominant bin.

Behaviour:
- Reset (ireset high at an edge):
  - All 36 bins, the sample counter and the scan index go to 0.
  - State goes to ACCUM.
  - Outputs: oready=1, ovalid=0, odir=0, opeak=0.
  - Reset has priority over everything, including mid-SCAN and the DONE cycle; no ovalid is produced for an aborted window.
- States:
  - ACCUM: oready=1. A sample is accepted on any edge with ivalid&oready.
  - SCAN: oready=0, lasts 36 cycles.
  - DONE: oready=0, ovalid=1, lasts 1 cycle, then back to ACCUM.
- Binning (combinational, same cycle):
  - bin = (iangle*36) >> ANG_W; result always in 0..35.
  - The accepted sample adds imag into bin[bin] at the accepting edge.
  - Addition saturates at 2^ACC_W-1; there is no wrap.
- Counter: increments per accepted sample. The edge accepting sample number WIN_SIZE moves to SCAN and zeroes the counter.
- ivalid while oready=0: ignored. The sample is dropped, not stalled; upstream must respect oready.
- SCAN:
  - Visits bins 0..35, one per cycle.
  - Running max uses strict greater-than, so on ties the lowest index wins.
  - All-zero histogram gives odir=0, opeak=0.
- DONE:
  - odir/opeak are updated and ovalid=1 for exactly one cycle.
  - All bins are cleared on the DONE edge.
  - oready returns to 1 the cycle after DONE.
- Latency: with the last sample accepted at edge T, ovalid is high in the cycle after edge T+36 (37 cycles). oready is low from the cycle after T through the DONE cycle.
- odir/opeak hold their value until the next DONE or reset.

Optional Feature:
- Macro: ORIENT_SMOOTH_EN.
- Defined:
  - SCAN compares smoothed values s[k] = (h[k-1] + 2*h[k] + h[k+1]) >> 2, with circular neighbours (h[-1]=h[35], h[36]=h[0]).
  - Intermediate sum is computed at ACC_W+2 bits.
  - opeak reports s[odir].
  - Latency and state timing are unchanged.
- Undefined: raw bins are compared; no smoothing logic is present.

Test Plan:
- Basic window, WIN_SIZE=4: samples (mag,angle) = (100,0x0000), (50,0x1C71), (70,0x1C72), (10,0xFFFF).
  - Bins: 0=100, 3=50, 4=70, 35=10.
  - Expect odir=0, opeak=100, ovalid 37 cycles after the last accept, single-cycle pulse.
- Tie-break, WIN_SIZE=2: (200,0x8000) -> bin 18; (200,0x4000) -> bin 9.
  - Expect odir=9, opeak=200.
- Saturation, ACC_W=17, WIN_SIZE=3: three samples (0xFFFF,0x0000).
  - Expect odir=0, opeak=131071.
- Backpressure and clear:
  - Hold ivalid high continuously through SCAN/DONE, sending (0xFFFF,0x8000); dropped samples must not affect the result.
  - Next window of WIN_SIZE samples (5,0x0000) gives odir=0, opeak=5*WIN_SIZE, proving the bins cleared.
- Reset mid-SCAN: assert ireset 10 cycles into SCAN.
  - No ovalid; oready=1 and odir=opeak=0 the cycle after reset.
  - A fresh window then completes normally.
- ORIENT_SMOOTH_EN, WIN_SIZE=3: bins 0=40, 1=40, 35=40 (angles 0x0000, 0x0720, 0xFF00).
  - Smoothed s0=40, s1=30, s35=30.
  - Expect odir=0, opeak=40.

Source files
------------

// File: rtl/sift_orient_hist_if.sv
// Sample/result interface for sift_orient_hist.
// master: upstream producer plus result consumer. slave: the histogram block.
// The widths set here must match the parameters of the sift_orient_hist instance.
interface sift_orient_hist_if #(
    parameter int unsigned MAG_W = 16,
    parameter int unsigned ANG_W = 16,
    parameter int unsigned ACC_W = 24
);
    logic             ivalid;
    logic [MAG_W-1:0] imag;
    logic [ANG_W-1:0] iangle;
    logic             oready;
    logic             ovalid;
    logic [5:0]       odir;
    logic [ACC_W-1:0] opeak;

    modport master (
        output ivalid, imag, iangle,
        input  oready, ovalid, odir, opeak
    );

    modport slave (
        input  ivalid, imag, iangle,
        output oready, ovalid, odir, opeak
    );
endinterface

// File: rtl/sift_orient_hist.sv
// SIFT keypoint orientation histogram.
// Accumulates WIN_SIZE (magnitude, angle) samples into 36 saturating bins, then scans
// the bins for 36 cycles and reports the dominant bin and its value for one cycle.
// Optional build macro ORIENT_SMOOTH_EN: the scan compares circularly smoothed bins
// (h[k-1] + 2*h[k] + h[k+1]) >> 2 instead of raw bins; timing is unchanged.
module sift_orient_hist #(
    parameter int unsigned WIN_SIZE = 256,
    parameter int unsigned MAG_W    = 16,
    parameter int unsigned ANG_W    = 16,
    parameter int unsigned ACC_W    = 24
) (
    input logic               iclk,
    input logic               ireset,
    sift_orient_hist_if.slave bus
);

    localparam int unsigned NBINS    = 36;
    localparam logic [5:0]  LAST_BIN = 6'd35;
    localparam logic [15:0] CNT_LAST = 16'(WIN_SIZE - 1);

    typedef enum logic [1:0] {StAccum, StScan, StDone} state_e;

    // State
    logic [ACC_W-1:0] r_bins [NBINS];
    state_e           r_state;
    logic [15:0]      r_cnt;
    logic [5:0]       r_idx;
    logic [5:0]       r_best_idx;
    logic [ACC_W-1:0] r_best_val;
    logic             r_oready;
    logic             r_ovalid;
    logic [5:0]       r_odir;
    logic [ACC_W-1:0] r_opeak;

    // Combinational
    logic             w_accept;
    logic [ANG_W+5:0] w_prod;
    logic [5:0]       w_bin;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_sat;
    logic [ACC_W-1:0] w_val;
    logic             w_gt;
    logic [5:0]       w_cand_idx;
    logic [ACC_W-1:0] w_cand_val;

    // oready is only high in StAccum, so accepts never overlap the scan or the clear.
    assign w_accept = bus.ivalid & r_oready;

    // Angle to bin: (angle * 36) >> ANG_W always lands in 0..35.
    assign w_prod = (ANG_W + 6)'(bus.iangle) * (ANG_W + 6)'(36);
    assign w_bin  = w_prod[ANG_W+5:ANG_W];

    // Saturating accumulate into the selected bin.
    assign w_add = {1'b0, r_bins[w_bin]} + (ACC_W + 1)'(bus.imag);
    assign w_sat = w_add[ACC_W] ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];

`ifdef ORIENT_SMOOTH_EN
    logic [5:0]       w_prev;
    logic [5:0]       w_next;
    logic [ACC_W+1:0] w_ssum;

    // Circular neighbours: bin 0 and bin 35 are adjacent.
    assign w_prev = (r_idx == 6'd0) ? LAST_BIN : r_idx - 6'd1;
    assign w_next = (r_idx == LAST_BIN) ? 6'd0 : r_idx + 6'd1;
    assign w_ssum = (ACC_W + 2)'(r_bins[w_prev]) + {1'b0, r_bins[r_idx], 1'b0}
                  + (ACC_W + 2)'(r_bins[w_next]);
    assign w_val  = w_ssum[ACC_W+1:2];
`else
    assign w_val = r_bins[r_idx];
`endif

    // Running max; strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_gt       = w_val > r_best_val;
        w_cand_idx = r_best_idx;
        w_cand_val = r_best_val;
        if (w_gt) begin
            w_cand_idx = r_idx;
            w_cand_val = w_val;
        end
    end

    // Histogram bins: cleared on reset and on the DONE edge, otherwise accumulate.
    always_ff @(posedge iclk) begin
        if (ireset || (r_state == StDone)) begin
            for (int k = 0; k < NBINS; k++) begin
                r_bins[k] <= '0;
            end
        end else if (w_accept) begin
            r_bins[w_bin] <= w_sat;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state    <= StAccum;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_oready   <= 1'b1;
            r_ovalid   <= 1'b0;
            r_odir     <= '0;
            r_opeak    <= '0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt      <= '0;
                            r_idx      <= '0;
                            r_best_idx <= '0;
                            r_best_val <= '0;
                            r_oready   <= 1'b0;
                            r_state    <= StScan;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                StScan: begin
                    r_best_idx <= w_cand_idx;
                    r_best_val <= w_cand_val;
                    if (r_idx == LAST_BIN) begin
                        // Last bin folded in here so results are valid in the DONE cycle.
                        r_idx    <= '0;
                        r_odir   <= w_cand_idx;
                        r_opeak  <= w_cand_val;
                        r_ovalid <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                StDone: begin
                    r_ovalid <= 1'b0;
                    r_oready <= 1'b1;
                    r_state  <= StAccum;
                end
                default: begin
                    r_state <= StAccum;
                end
            endcase
        end
    end

    assign bus.oready = r_oready;
    assign bus.ovalid = r_ovalid;
    assign bus.odir   = r_odir;
    assign bus.opeak  = r_opeak;

endmodule

// File: tb/tb_sift_orient_hist.sv
// Directed bench for sift_orient_hist (WIN_SIZE=4, ACC_W=17 so saturation is reachable).
// Expected values are hand-computed for raw bins, or for smoothed bins under
// ORIENT_SMOOTH_EN.
module tb_sift_orient_hist;

    localparam int unsigned WIN_SIZE = 4;
    localparam int unsigned MAG_W    = 16;
    localparam int unsigned ANG_W    = 16;
    localparam int unsigned ACC_W    = 17;

`ifdef ORIENT_SMOOTH_EN
    localparam int unsigned EXP_BASIC = 52;
    localparam int unsigned EXP_TIE   = 100;
    localparam int unsigned EXP_SAT   = 65535;
    localparam int unsigned EXP_CLEAR = 10;
`else
    localparam int unsigned EXP_BASIC = 100;
    localparam int unsigned EXP_TIE   = 200;
    localparam int unsigned EXP_SAT   = 131071;
    localparam int unsigned EXP_CLEAR = 20;
`endif
    localparam int unsigned EXP_FRESH = 40;

    logic iclk = 1'b0;
    logic ireset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 iclk = ~iclk;

    sift_orient_hist_if #(.MAG_W(MAG_W), .ANG_W(ANG_W), .ACC_W(ACC_W)) bus ();

    sift_orient_hist #(
        .WIN_SIZE(WIN_SIZE),
        .MAG_W   (MAG_W),
        .ANG_W   (ANG_W),
        .ACC_W   (ACC_W)
    ) dut (
        .iclk  (iclk),
        .ireset(ireset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Present one sample for one accepting edge.
    task automatic send(input logic [15:0] mag, input logic [15:0] ang);
        @(negedge iclk);
        bus.ivalid = 1'b1;
        bus.imag   = mag;
        bus.iangle = ang;
    endtask

    // Close the window after the last send; optionally keep pushing a sample that
    // would land in bin 18 with a huge value, which the block must drop.
    task automatic end_window(input bit hold);
        @(negedge iclk);
        if (hold) begin
            bus.imag   = 16'hFFFF;
            bus.iangle = 16'h8000;
        end else begin
            bus.ivalid = 1'b0;
        end
    endtask

    // Called at the negedge after the last accepting edge T.
    task automatic wait_result(input string tag, input int unsigned want_dir,
                               input int unsigned want_peak);
        bit seen = 1'b0;
        check_eq({tag, "_oready_low"}, 32'(bus.oready), 32'd0);
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge iclk);
            if (bus.ovalid) begin
                seen = 1'b1;
                bus.ivalid = 1'b0;
                check_eq({tag, "_latency"}, 32'(k), 32'd36);
                check_eq({tag, "_dir"}, 32'(bus.odir), want_dir);
                check_eq({tag, "_peak"}, 32'(bus.opeak), want_peak);
                @(negedge iclk);
                check_eq({tag, "_pulse_end"}, 32'(bus.ovalid), 32'd0);
                check_eq({tag, "_oready_back"}, 32'(bus.oready), 32'd1);
                check_eq({tag, "_hold_peak"}, 32'(bus.opeak), want_peak);
            end
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int pulses;
        ireset     = 1'b1;
        bus.ivalid = 1'b0;
        bus.imag   = '0;
        bus.iangle = '0;
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        check_eq("rst_oready", 32'(bus.oready), 32'd1);
        check_eq("rst_ovalid", 32'(bus.ovalid), 32'd0);
        check_eq("rst_odir", 32'(bus.odir), 32'd0);
        check_eq("rst_opeak", 32'(bus.opeak), 32'd0);

        // Bins 0=100, 3=50, 4=70, 35=10.
        send(16'd100, 16'h0000);
        send(16'd50, 16'h1C71);
        send(16'd70, 16'h1C72);
        send(16'd10, 16'hFFFF);
        end_window(1'b0);
        wait_result("basic", 0, EXP_BASIC);

        // Equal peaks at bins 18 and 9: lowest index wins.
        send(16'd200, 16'h8000);
        send(16'd200, 16'h4000);
        send(16'd0, 16'h0000);
        send(16'd0, 16'h0000);
        end_window(1'b0);
        wait_result("tie", 9, EXP_TIE);

        // Bin 0 saturates at 2^17-1; ivalid stays high through SCAN/DONE.
        repeat (4) send(16'hFFFF, 16'h0000);
        end_window(1'b1);
        wait_result("sat", 0, EXP_SAT);

        // Dropped samples and the DONE clear must leave only this window.
        repeat (4) send(16'd5, 16'h0000);
        end_window(1'b0);
        wait_result("clear", 0, EXP_CLEAR);

        // Reset 10 cycles into SCAN aborts the window without a result.
        send(16'd100, 16'h0000);
        send(16'd50, 16'h1C71);
        send(16'd70, 16'h1C72);
        send(16'd10, 16'hFFFF);
        end_window(1'b0);
        repeat (10) @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        ireset = 1'b0;
        check_eq("abort_oready", 32'(bus.oready), 32'd1);
        check_eq("abort_ovalid", 32'(bus.ovalid), 32'd0);
        check_eq("abort_odir", 32'(bus.odir), 32'd0);
        check_eq("abort_opeak", 32'(bus.opeak), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge iclk);
            if (bus.ovalid) pulses++;
        end
        check_eq("abort_no_ovalid", 32'(pulses), 32'd0);

        // Fresh window: bins 0=1=35=40; raw tie and smoothed peak both pick bin 0.
        send(16'd40, 16'h0000);
        send(16'd40, 16'h0720);
        send(16'd40, 16'hFF00);
        send(16'd0, 16'h0000);
        end_window(1'b0);
        wait_result("fresh", 0, EXP_FRESH);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
